// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 opcodes,
// FSM states, special-case result constants and operand-signedness helpers.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FASTMUL_EN to compute all MUL* ops in a single cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] RS1_data,
    input  logic [WIDTH-1:0] RS2_data,
    input  logic [4:0]       RD_in,
    output logic             busy,
    output logic             done,
    output logic [4:0]       RD,
    output logic [WIDTH-1:0] RD_data,
    output logic             write_en
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wen_q, wen_d;

    // Apply the result sign to a product magnitude and pick the requested half.
    function automatic logic [WIDTH-1:0] mul_pick(input logic [2:0] f, input logic neg,
                                                  input logic [DW-1:0] mag);
        logic [DW-1:0] p;
        p = neg ? -mag : mag;
        return (f == F3_MUL) ? p[WIDTH-1:0] : p[DW-1:WIDTH];
    endfunction

    // Operand decode in IDLE: magnitudes, result sign and special cases.
    logic             a_sgn, b_sgn, is_div, is_rem, start_neg, div_zero, div_ovf;
    logic [WIDTH-1:0] a_abs, b_abs, special_res;

    assign a_sgn     = rs1_is_signed(funct3) & RS1_data[WIDTH-1];
    assign b_sgn     = rs2_is_signed(funct3) & RS2_data[WIDTH-1];
    assign a_abs     = a_sgn ? -RS1_data : RS1_data;
    assign b_abs     = b_sgn ? -RS2_data : RS2_data;
    assign is_div    = op_is_div(funct3);
    assign is_rem    = funct3[1];
    assign start_neg = (is_div && is_rem) ? a_sgn : (a_sgn ^ b_sgn);
    assign div_zero  = is_div && (RS2_data == '0);
    assign div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                       && (RS1_data == MIN_NEG) && (RS2_data == ONES);
    assign special_res = div_zero ? (is_rem ? RS1_data : ONES)
                                  : (is_rem ? '0 : MIN_NEG);

    logic             fast_hit;
    logic [WIDTH-1:0] fast_res;
`ifdef MULDIV_FASTMUL_EN
    assign fast_hit = !is_div;
    assign fast_res = mul_pick(funct3, start_neg, DW'(a_abs) * DW'(b_abs));
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // Multiply step: acc = {partial high, remaining multiplier bits}.
    logic [WIDTH:0]  mul_sum;
    logic [DW-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]   rem_sh, div_diff;
    logic             q_bit;
    logic [DW-1:0]    div_next;
    assign rem_sh   = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, opnd_q};
    assign q_bit    = ~div_diff[WIDTH];
    assign div_next = {(q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], q_bit};

    logic [WIDTH-1:0] div_mag, div_res, fix_res;
    assign div_mag = op_q[1] ? acc_q[DW-1:WIDTH] : acc_q[WIDTH-1:0];
    assign div_res = neg_q ? -div_mag : div_mag;
    assign fix_res = op_q[2] ? div_res : mul_pick(op_q, neg_q, acc_q);

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wen_d   = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    rd_d  = RD_in;
                    neg_d = start_neg;
                    cnt_d = '0;
                    if (is_div) begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                    end
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = ST_DONE;
                    end else if (fast_hit) begin
                        res_d   = fast_res;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                res_d   = fix_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort leaves the previously written result untouched.
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            res_d   = res_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        wen_d  = !done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign RD       = rd_q;
    assign RD_data  = res_q;
    assign write_en = wen_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, checked on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  funct3;
    logic [31:0] RS1_data, RS2_data;
    logic [4:0]  RD_in;
    logic        busy, done, write_en;
    logic [4:0]  RD;
    logic [31:0] RD_data;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .RS1_data(RS1_data), .RS2_data(RS2_data), .RD_in(RD_in),
        .busy(busy), .done(done), .RD(RD), .RD_data(RD_data), .write_en(write_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          prev_done = 1'b0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: 64-bit product with explicit extension, SV native signed division.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [31:0] r;
        ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        case (f)
            3'b000: r = p[31:0];
            3'b001, 3'b010, 3'b011: r = p[63:32];
            3'b100: if (b == 0) r = 32'hFFFF_FFFF;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                    else r = $signed(a) / $signed(b);
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: if (b == 0) r = a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                    else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 0;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FASTMUL_EN
        if (!f[2]) return 0;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (prev_done) begin
            check("wen_pulse", {31'b0, write_en}, 32'd1);
            prev_done = 1'b0;
        end
        if (done) begin
            prev_done = 1'b1;
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                last_res = e.data;
                check("rd_data", RD_data, e.data);
                check("rd", {27'b0, RD}, {27'b0, e.rd});
                check("wen_low", {31'b0, write_en}, 32'd0);
                check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        wait_idle();
        @(negedge clk);
        funct3 = f; RS1_data = a; RS2_data = b; RD_in = rd; start = 1'b1;
        if (push) sb.push_back('{data: ref_res(f, a, b), rd: rd, lat: ref_lat(f, a, b)});
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        start    = 1'b0;
        RS1_data = $urandom;
        RS2_data = $urandom;
        RD_in    = 5'($urandom);
        funct3   = 3'($urandom);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          bad;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        RS1_data = '0; RS2_data = '0; RD_in = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wen", {31'b0, write_en}, 32'd1);
        check("rst_rd", {27'b0, RD}, 32'd0);
        check("rst_rd_data", RD_data, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
        issue(3'b101, 32'd100, 32'd7, 5'd7, 1'b1);
        issue(3'b111, 32'd100, 32'd7, 5'd8, 1'b1);
        issue(3'b100, 32'h1234_5678, 32'd0, 5'd9, 1'b1);
        issue(3'b111, 32'h1234_5678, 32'd0, 5'd10, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            issue(3'($urandom), ra, rb, 5'($urandom), 1'b1);
        end
        wait_idle();

        // Flush mid-divide: no writeback, previous result held.
        issue(3'b101, 32'hDEAD_BEEF, 32'd3, 5'd20, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_rd_data", RD_data, last_res);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!write_en || done) bad++;
        end
        check("flush_quiet", 32'(bad), 32'd0);
        check("flush_hold", RD_data, last_res);

        // Flush in IDLE blocks a simultaneous start.
        @(negedge clk);
        funct3 = 3'b101; RS1_data = 32'd9; RS2_data = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", {31'b0, busy}, 32'd0);

        // A second start during CALC is ignored.
        issue(3'b100, 32'd1000, 32'hFFFF_FFF6, 5'd21, 1'b1);
        repeat (5) @(negedge clk);
        funct3 = 3'b000; RS1_data = 32'd5; RS2_data = 32'd5; RD_in = 5'd22; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-CALC.
        issue(3'b011, 32'h0F0F_0F0F, 32'h1234_5678, 5'd23, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_wen", {31'b0, write_en}, 32'd1);
        check("arst_rd", {27'b0, RD}, 32'd0);
        check("arst_rd_data", RD_data, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd17, 1'b1);
        wait_idle();
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
